load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sequences RV32I loads and stores onto a single-ported word memory,
// using read-modify-write for byte and halfword stores.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_error_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wr_data_o,
  output logic              mem_wr_enable_o,
  output logic              mem_rd_enable_o,
  input  logic [31:0]       mem_rd_data_i
);

  typedef enum logic [2:0] {
    IDLE, LOAD_RD, LOAD_WAIT, STORE_RD, STORE_MERGE, STORE_WR, RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_active;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_error;

  logic              w_accept;
  logic              w_legal;
  logic              w_misaligned;
  logic              w_reqError;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_loadData;
  logic [31:0]       w_mergeData;

  assign w_accept    = req_valid_i && req_ready_o;
  assign mem_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
  assign rsp_rdata_o = r_rdata;
  assign rsp_error_o = r_error;

  always_comb begin
    w_legal = 1'b0;
    if (req_we_i) begin
      w_legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                (req_funct3_i == 3'b010);
    end else begin
      case (req_funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default:                                w_legal = 1'b0;
      endcase
    end
  end

  assign w_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                        ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  assign w_reqError   = !w_legal || w_misaligned;

  // r_active keeps ready low during reset and on the reset edge itself
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_state  <= IDLE;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_active <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_reqError)                          w_next = RESP;
          else if (!req_we_i)                      w_next = LOAD_RD;
          else if (req_funct3_i[1:0] == 2'b10)     w_next = STORE_WR;
          else                                     w_next = STORE_RD;
        end
      end
      LOAD_RD:     w_next = LOAD_WAIT;
      LOAD_WAIT:   w_next = RESP;
      STORE_RD:    w_next = STORE_MERGE;
      STORE_MERGE: w_next = STORE_WR;
      STORE_WR:    w_next = RESP;
      RESP:        w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o     = 1'b0;
    rsp_valid_o     = 1'b0;
    mem_rd_enable_o = 1'b0;
    mem_wr_enable_o = 1'b0;
    mem_wr_data_o   = '0;
    case (r_state)
      IDLE:              req_ready_o     = r_active;
      LOAD_RD, STORE_RD: mem_rd_enable_o = 1'b1;
      STORE_WR: begin
        mem_wr_enable_o = 1'b1;
        mem_wr_data_o   = r_wdata;
      end
      RESP:              rsp_valid_o     = 1'b1;
      default: ;
    endcase
  end

  // Little-endian lane selection for loads and sub-word store merging
  always_comb begin
    w_byte = mem_rd_data_i[{r_addr[1:0], 3'b000} +: 8];
    w_half = mem_rd_data_i[{r_addr[1], 4'b0000} +: 16];
    case (r_funct3[1:0])
      2'b00:   w_loadData = {{24{!r_funct3[2] && w_byte[7]}}, w_byte};
      2'b01:   w_loadData = {{16{!r_funct3[2] && w_half[15]}}, w_half};
      default: w_loadData = mem_rd_data_i;
    endcase
    w_mergeData = mem_rd_data_i;
    if (r_funct3[1:0] == 2'b00) begin
      w_mergeData[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_mergeData[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_funct3 <= req_funct3_i;
            r_addr   <= req_addr_i;
            r_wdata  <= req_wdata_i;
            if (w_reqError) begin
              r_rdata <= '0;
              r_error <= 1'b1;
            end
          end
        end
        LOAD_WAIT: begin
          r_rdata <= w_loadData;
          r_error <= 1'b0;
        end
        STORE_MERGE: r_wdata <= w_mergeData;
        STORE_WR: begin
          r_rdata <= '0;
          r_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
